// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO transmitter.
// Parity bit appended when SHIFT_REG_PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

`ifdef SHIFT_REG_PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Bits per serial frame: data word plus optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    return parity_en ? (width + 32'd1) : width;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned frame);
    return (frame < 32'd1) ? 32'd1 : 32'($clog2(frame + 32'd1));
  endfunction

endpackage

// File: rtl/piso_frame_counter.sv
// Bit-position counter for one serial frame: clear-on-load, terminal-count flag.
module piso_frame_counter
  import piso_pkg::*;
#(
  parameter  int unsigned FRAME = 4,
  localparam int unsigned CW    = cnt_width(FRAME)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          en,
  output logic          tc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(FRAME - 32'd1);

  logic [CW-1:0] r_cnt;

  // Counts 0..FRAME-1 and returns to 0 after the terminal position; never wraps past it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tc ? '0 : (r_cnt + CW'(1));
    end
  end

  assign tc  = (r_cnt == LAST);
  assign cnt = r_cnt;

endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready intake and gapless frames.
// Optional trailing even-parity bit under SHIFT_REG_PISO_PARITY_EN.
module shift_reg_piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_first,
  output logic             busy
);

  localparam int unsigned FRAME = frame_len(WIDTH, PARITY_EN);
  localparam int unsigned CW    = cnt_width(FRAME);
  localparam int unsigned SR_W  = FRAME;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_ready;
  logic              w_cnt_en;
  logic              w_xfer;
  logic              w_tc;
  logic [CW-1:0]     w_cnt;
  logic [SR_W-1:0]   r_sr;
  logic [SR_W-1:0]   w_load;
  logic [SR_W-1:0]   w_shift;
  logic              r_first;

  // Word as loaded into the shift register; parity sits at the tail of the frame.
`ifdef SHIFT_REG_PISO_PARITY_EN
  assign w_load = MSB_FIRST ? {d, ^d} : {^d, d};
`else
  assign w_load = d;
`endif

  assign w_shift = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
  assign w_xfer  = d_valid && w_ready;

  piso_frame_counter #(
    .FRAME (FRAME)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_xfer),
    .en      (w_cnt_en),
    .tc      (w_tc),
    .cnt     (w_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready in IDLE and on the last frame bit so a new word can follow without a gap.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (d_valid) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          w_ready = 1'b1;
          if (!d_valid) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Zeros shift in behind the word, so q returns to 0 once the frame has drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr    <= '0;
      r_first <= 1'b0;
    end else begin
      r_first <= w_xfer;
      if (w_xfer) begin
        r_sr <= w_load;
      end else if (r_state == ST_SHIFT) begin
        r_sr <= w_shift;
      end
    end
  end

  assign d_ready = w_ready;
  assign q       = MSB_FIRST ? r_sr[SR_W-1] : r_sr[0];
  assign q_valid = (r_state == ST_SHIFT);
  assign q_first = r_first;
  assign busy    = q_valid;

  // Counter must be parked at zero whenever no frame is in flight.
  a_idle_cnt_zero : assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == ST_IDLE) |-> (w_cnt == '0));

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Self-checking bench: three transmitter configurations against a bit-queue frame model.
module tb_shift_reg_piso_tx;

`ifdef SHIFT_REG_PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NI = 3;

  typedef struct packed {
    logic b;
    logic f;
  } mbit_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] d_in [NI];
  logic       dv   [NI];
  logic       o_r  [NI];
  logic       o_q  [NI];
  logic       o_v  [NI];
  logic       o_f  [NI];
  logic       o_b  [NI];
  logic [0:0] d_w1;

  mbit_t mq [NI][$];
  logic  e_q [NI];
  logic  e_v [NI];
  logic  e_f [NI];
  logic  e_r [NI];
  logic  acc [NI];
  int    n_chk = 0;
  int    n_fail = 0;

  assign d_w1 = d_in[2][0:0];

  shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .d(d_in[0]), .d_valid(dv[0]), .d_ready(o_r[0]),
    .q(o_q[0]), .q_valid(o_v[0]), .q_first(o_f[0]), .busy(o_b[0]));

  shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .d(d_in[1]), .d_valid(dv[1]), .d_ready(o_r[1]),
    .q(o_q[1]), .q_valid(o_v[1]), .q_first(o_f[1]), .busy(o_b[1]));

  shift_reg_piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .d(d_w1), .d_valid(dv[2]), .d_ready(o_r[2]),
    .q(o_q[2]), .q_valid(o_v[2]), .q_first(o_f[2]), .busy(o_b[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit msb(input int i);
    return (i != 1);
  endfunction

  // Append one frame: data bits in transmit order, then optional even parity.
  task automatic push_frame(input int i, input logic [3:0] w);
    mbit_t e;
    logic  par;
    int    idx;
    par = 1'b0;
    for (int k = 0; k < wid(i); k++) begin
      idx = msb(i) ? (wid(i) - 1 - k) : k;
      e.b = w[idx];
      e.f = (k == 0);
      par = par ^ w[idx];
      mq[i].push_back(e);
    end
    if (PAR) begin
      e.b = par;
      e.f = 1'b0;
      mq[i].push_back(e);
    end
  endtask

  task automatic model_eval();
    for (int i = 0; i < NI; i++) begin
      e_v[i] = (mq[i].size() > 0);
      e_q[i] = (mq[i].size() > 0) ? mq[i][0].b : 1'b0;
      e_f[i] = (mq[i].size() > 0) ? mq[i][0].f : 1'b0;
      e_r[i] = (mq[i].size() <= 1);
    end
  endtask

  task automatic model_clock();
    mbit_t drop;
    for (int i = 0; i < NI; i++) begin
      acc[i] = 1'b0;
      if (!reset_n) begin
        mq[i].delete();
      end else begin
        acc[i] = dv[i] && (mq[i].size() <= 1);
        if (mq[i].size() > 0) drop = mq[i].pop_front();
        if (acc[i]) push_frame(i, d_in[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      dv[i] = 1'b1;
      d_in[i] = 4'hF;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); model_eval();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== 5'b00001) begin
          n_fail++;
          $display("FAIL reset inst%0d c%0d q,v,f,busy,rdy got %b exp 00001", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
    end
    for (int i = 0; i < NI; i++) dv[i] = 1'b0;
    #2 reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); model_eval();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]}) begin
          n_fail++;
          $display("FAIL post_reset inst%0d c%0d q,v,f,busy,rdy got %b exp %b", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]}, {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
    end
  endtask

  task automatic test_single();
    d_in[0] = 4'b1011;
    d_in[1] = 4'b0001;
    d_in[2] = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NI; i++) dv[i] = (c == 0);
      @(negedge clk); model_eval();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]}) begin
          n_fail++;
          $display("FAIL single inst%0d c%0d q,v,f,busy,rdy got %b exp %b", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]}, {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [2];
    int         idx [2];
    words[0] = 4'hA;
    words[1] = 4'h5;
    idx[0] = 0;
    idx[1] = 0;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < 2; i++) begin
        dv[i]   = (idx[i] < 2);
        d_in[i] = (idx[i] < 2) ? words[idx[i]] : 4'($urandom);
      end
      dv[2]   = (c < 10);
      d_in[2] = 4'(c & 1);
      @(negedge clk); model_eval();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]}) begin
          n_fail++;
          $display("FAIL back_to_back inst%0d c%0d q,v,f,busy,rdy got %b exp %b", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]}, {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
      for (int i = 0; i < 2; i++) if (acc[i]) idx[i]++;
    end
  endtask

  task automatic test_ignore_midframe();
    int sent [2];
    sent[0] = 0;
    sent[1] = 0;
    dv[2] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        dv[i]   = (sent[i] < 2);
        d_in[i] = (sent[i] == 0) ? 4'hC : ((sent[i] == 1) ? 4'h3 : 4'($urandom));
      end
      @(negedge clk); model_eval();
      if (c == 2) begin
        n_chk++;
        if (o_r[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL midframe_ready got %b exp 0", o_r[0]);
        end
      end
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]}) begin
          n_fail++;
          $display("FAIL ignore_midframe inst%0d c%0d q,v,f,busy,rdy got %b exp %b", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]}, {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
      for (int i = 0; i < 2; i++) if (acc[i]) sent[i]++;
    end
  endtask

  task automatic test_reset_midframe();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NI; i++) begin
        dv[i]   = (c == 0);
        d_in[i] = 4'hF;
      end
      @(negedge clk); model_eval();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]}) begin
          n_fail++;
          $display("FAIL pre_abort inst%0d c%0d q,v,f,busy,rdy got %b exp %b", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]}, {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if ({o_q[i], o_v[i], o_f[i], o_b[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL async_abort inst%0d q,v,f,busy got %b exp 0000", i,
                 {o_q[i], o_v[i], o_f[i], o_b[i]});
      end
      mq[i].delete();
      dv[i] = 1'b1;
    end
    repeat (2) begin
      @(posedge clk); model_clock(); #1;
    end
    for (int i = 0; i < NI; i++) dv[i] = 1'b0;
    #3 reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); model_eval();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]}) begin
          n_fail++;
          $display("FAIL after_abort inst%0d c%0d q,v,f,busy,rdy got %b exp %b", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]}, {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        dv[i]   = ($urandom_range(0, 3) != 0);
        d_in[i] = 4'($urandom);
      end
      @(negedge clk); model_eval();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if ({o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]} !== {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]}) begin
          n_fail++;
          $display("FAIL random inst%0d c%0d q,v,f,busy,rdy got %b exp %b", i, c,
                   {o_q[i], o_v[i], o_f[i], o_b[i], o_r[i]}, {e_q[i], e_v[i], e_f[i], e_v[i], e_r[i]});
        end
      end
      @(posedge clk); model_clock(); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      dv[i]   = 1'b0;
      d_in[i] = 4'h0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/shift_reg_piso_tx.md
Name: shift_reg_piso_tx

Overview:
Parallel-in serial-out transmitter. It is the serialising end of the team's 4-bit parallel data path (the counterpart to the PIPO/SIPO registers). It accepts a parallel word over a valid/ready handshake and drives it out one bit per clock, with frame-marker and valid strobes, into a downstream serial receiver (SIPO). Gapless back-to-back frames are supported.

Parameters:
WIDTH, 4, parallel word width in bits; legal range 1 to 32.
MSB_FIRST, 1, 1 = transmit d[WIDTH-1] first; 0 = transmit d[0] first.

Ports:
clk  input  1  system clock; all flops are rising-edge.
reset_n  input  1  asynchronous active-low reset.
d  input  WIDTH  parallel data word.
d_valid  input  1  d holds a word to send.
d_ready  output  1  transmitter can accept a word this cycle.
q  output  1  serial data bit.
q_valid  output  1  q carries a frame bit this cycle.
q_first  output  1  q carries the first bit of a frame.
busy  output  1  a frame is in progress.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset state while reset_n = 0: state = IDLE, shift register = 0, bit counter = 0, q = 0, q_valid = 0, q_first = 0, busy = 0. d_ready reads 1 (combinational from IDLE), but no transfer is taken while reset is asserted.
- Frame length: FRAME = WIDTH, or WIDTH+1 when the parity option is enabled.
- Transfer: a word is accepted on a rising edge where d_valid && d_ready. d is captured into the shift register only on a transfer; d and d_valid are ignored at all other times.
- States:
  - IDLE: d_ready = 1. A transfer moves the block to SHIFT with counter = 0.
  - SHIFT: on each edge, the shift register advances one bit toward the output end and the counter increments.
    - At counter = FRAME-1, the block returns to IDLE unless a transfer occurs on that same edge; in that case it reloads, stays in SHIFT and resets counter = 0.
- d_ready = (state == IDLE) || (state == SHIFT && counter == FRAME-1). This allows a gapless stream.
- Latency: a word accepted at edge k drives its first bit on q from edge k until edge k+1. Bit i is driven in cycle k+i. q_valid = 1 for exactly FRAME consecutive cycles.
- q_first = 1 only in the cycle when counter = 0 in SHIFT.
- busy equals q_valid.
- Outputs q, q_valid and q_first come straight from flops, with no combinational path from d.
- Bit order: MSB_FIRST=1 shifts left and q = sr[WIDTH-1]. MSB_FIRST=0 shifts right and q = sr[0].
- After the last bit with no new transfer: q_valid = 0 and q = 0.
- WIDTH = 1, no parity: d_ready is permanently 1; each transfer yields a one-cycle frame, and q_first = q_valid.
- d_valid deasserted in mid-frame has no effect; the frame always completes.
- Reset asserted mid-frame: the frame is abandoned and q_valid falls immediately (asynchronously). After release, the block is in IDLE and no residual bits are sent.
- Counter width: $clog2(FRAME+1) bits; it never wraps past FRAME-1.

Optional Feature:
Macro: SHIFT_REG_PISO_PARITY_EN.
- Defined: an even-parity bit (XOR of the accepted word) is captured at transfer and sent as an extra final bit. FRAME = WIDTH+1, and d_ready asserts during the parity cycle.
- Undefined: no parity logic or storage exists; FRAME = WIDTH.

Decomposition:
- Shared package piso_pkg:
  - state localparams ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
  - function frame_len(width, parity_en);
  - function cnt_width(frame).
- One natural sub-module, piso_frame_counter: a loadable up-counter with clear-on-load and a terminal-count flag (counter == FRAME-1). It is parameterised by FRAME and has clk/reset_n, load, en, tc, cnt.
- The datapath and FSM stay in the top module.

Test Plan:
1. Reset, then WIDTH=4, MSB_FIRST=1, d=4'b1011 with one-cycle d_valid -> q = 1,0,1,1 on four consecutive cycles; q_valid high for 4 cycles; q_first high only in the first; then q_valid = 0.
2. d_valid held high, d=4'hA then 4'h5 presented at each d_ready -> 8 contiguous q_valid cycles carrying 1010 0101, with q_first at cycles 0 and 4 and no gap.
3. Mid-frame (bit 2 of 4'hC), d=4'h3 with d_valid=1 -> d_ready=0, word not taken, current frame 1100 completes unchanged, then 0011 follows when d_ready rises.
4. Assert reset_n=0 after 2 bits of 4'hF (at a non-edge time, e.g. 0.3 us into the cycle) -> q_valid and q go to 0 immediately; after release, q_valid stays 0 until a new transfer.
5. MSB_FIRST=0, d=4'b0001 -> q = 1,0,0,0. WIDTH=1 with d_valid always 1 and d toggling -> q follows d delayed one cycle, with q_valid continuously 1.
6. SHIFT_REG_PISO_PARITY_EN defined, d=4'b1011 -> five bits 1,0,1,1,1; d=4'b1001 -> parity bit 0; d_ready=1 in the parity cycle.
